// File: rtl/drac_icache_pkg.sv
// drac_icache_pkg: shared widths, packet layout, command and FSM types for the
// icache invalidation producer.
package drac_icache_pkg;
    localparam int ICACHE_IDX_WIDTH = 8;
    localparam int ICACHE_N_WAY     = 4;
    localparam int ICACHE_WAY_WIDTH = $clog2(ICACHE_N_WAY);

    localparam int PKT_VALID    = 15;
    localparam int PKT_ALL_WAYS = 14;
    localparam int PKT_IDX_HI   = 13;
    localparam int PKT_IDX_LO   = 6;
    localparam int PKT_WAY_HI   = 1;
    localparam int PKT_WAY_LO   = 0;

    typedef struct packed {
        logic                        walk;
        logic                        all_ways;
        logic [ICACHE_IDX_WIDTH-1:0] index;
        logic [ICACHE_WAY_WIDTH-1:0] way;
    } inval_cmd_t;

    typedef struct packed {
        logic                        valid;
        logic                        all_ways;
        logic [ICACHE_IDX_WIDTH-1:0] index;
        logic [3:0]                  zero;
        logic [ICACHE_WAY_WIDTH-1:0] way;
    } inval_pkt_t;

    typedef enum logic [1:0] {S_IDLE, S_SINGLE, S_WALK} inval_state_e;
endpackage

// File: rtl/icache_inval_fifo.sv
// icache_inval_fifo: parametric synchronous FIFO with full/empty flags; push
// when full and pop when empty are ignored.
module icache_inval_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             wr_en, rd_en;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign rdata = mem[rd_ptr];
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        end
    end
endmodule

// File: rtl/icache_inval_gen.sv
// icache_inval_gen: queues single-line/whole-cache invalidation commands and emits one
// 16-bit packet per line. ICACHE_INVAL_CNT_EN adds accepted-packet and walk counters.
module icache_inval_gen
    import drac_icache_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = ICACHE_IDX_WIDTH,
    parameter int N_WAY      = ICACHE_N_WAY
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_walk_i,
    input  logic                     cmd_all_ways_i,
    input  logic [IDX_W-1:0]         cmd_index_i,
    input  logic [$clog2(N_WAY)-1:0] cmd_way_i,
    input  logic                     flush_ena_i,
    input  logic                     stall_i,
    output logic [15:0]              inval_o,
    output logic                     busy_o,
    output logic                     done_o
`ifdef ICACHE_INVAL_CNT_EN
    ,
    output logic [31:0]              inval_cnt_o,
    output logic [15:0]              walk_cnt_o
`endif
);
    inval_cmd_t   in_cmd, head, cur, next_cmd;
    inval_pkt_t   pkt;
    inval_state_e state, state_n;
    logic [IDX_W-1:0] idx;
    logic empty, full, accept, last, load, pop, bypass, push;

    assign in_cmd = '{walk: cmd_walk_i, all_ways: cmd_all_ways_i, index: cmd_index_i, way: cmd_way_i};
    assign cmd_ready_o = ~full;
    assign accept   = (state != S_IDLE) & ~flush_ena_i & ~stall_i;
    assign last     = (state == S_SINGLE) | ((state == S_WALK) & (&idx));
    assign load     = (state == S_IDLE) | (accept & last);
    assign pop      = load & ~empty;
    // An empty FIFO hands a new command straight to the sequencer to save a cycle.
    assign bypass   = load & empty & cmd_valid_i;
    assign push     = cmd_valid_i & ~full & ~bypass;
    assign next_cmd = pop ? head : in_cmd;
    assign busy_o   = ~empty | (state != S_IDLE);
    assign inval_o  = pkt;

    icache_inval_fifo #(.WIDTH($bits(inval_cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata (in_cmd),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_n = state;
        if (load) state_n = (pop | bypass) ? (next_cmd.walk ? S_WALK : S_SINGLE) : S_IDLE;
    end

    always_comb begin
        pkt = '0;
        if (state != S_IDLE) begin
            pkt.valid    = 1'b1;
            pkt.all_ways = cur.walk | cur.all_ways;
            pkt.index    = cur.walk ? idx : cur.index;
            pkt.way      = (cur.walk | cur.all_ways) ? '0 : cur.way;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            cur    <= '0;
            idx    <= '0;
            done_o <= 1'b0;
        end else begin
            state  <= state_n;
            done_o <= accept & last;
            if (pop | bypass) cur <= next_cmd;
            if (accept & cur.walk) idx <= idx + 1'b1;
        end
    end

`ifdef ICACHE_INVAL_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inval_cnt_o <= '0;
            walk_cnt_o  <= '0;
        end else begin
            if (accept & ~&inval_cnt_o) inval_cnt_o <= inval_cnt_o + 1'b1;
            if (accept & last & cur.walk) walk_cnt_o <= walk_cnt_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_inval_gen.sv
// tb_icache_inval_gen: directed scenarios plus randomized traffic checked against a
// packet-list scoreboard expanded from each accepted command.
module tb_icache_inval_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_walk = 1'b0, cmd_all_ways = 1'b0;
    logic [7:0]  cmd_index = '0;
    logic [1:0]  cmd_way = '0;
    logic        flush = 1'b0, stall = 1'b0;
    logic        cmd_ready, busy, done;
    logic [15:0] inval;
`ifdef ICACHE_INVAL_CNT_EN
    logic [31:0] inval_cnt;
    logic [15:0] walk_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] pkt;
        bit          last;
    } exp_t;
    exp_t        exp_q[$];
    bit          exp_done = 0;
    bit          have_prev = 0;
    logic [15:0] prev_pkt = '0;

    icache_inval_gen dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_walk_i     (cmd_walk),
        .cmd_all_ways_i (cmd_all_ways),
        .cmd_index_i    (cmd_index),
        .cmd_way_i      (cmd_way),
        .flush_ena_i    (flush),
        .stall_i        (stall),
        .inval_o        (inval),
        .busy_o         (busy),
        .done_o         (done)
`ifdef ICACHE_INVAL_CNT_EN
        ,
        .inval_cnt_o    (inval_cnt),
        .walk_cnt_o     (walk_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic aw, input logic [7:0] ix, input logic [1:0] w);
        return {1'b1, aw, ix, 4'b0000, aw ? 2'b00 : w};
    endfunction

    // Scoreboard: every accepted packet must be the next one owed, held packets must not move.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_done  = 0;
            have_prev = 0;
        end else begin
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL sb_done: got %b want %b at %0t", done, exp_done, $time);
            end
            exp_done = 0;
            if (have_prev) begin
                checks++;
                if (inval !== prev_pkt) begin
                    errors++;
                    $display("FAIL sb_stable: got %h want %h at %0t", inval, prev_pkt, $time);
                end
            end
            if (inval[15] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got %h want no packet at %0t", inval, $time);
                end else if (inval !== exp_q[0].pkt) begin
                    errors++;
                    $display("FAIL sb_order: got %h want %h at %0t", inval, exp_q[0].pkt, $time);
                end
            end
            if (inval[15] === 1'b1 && !flush && !stall) begin
                if (exp_q.size() != 0) begin
                    exp_done = exp_q[0].last;
                    void'(exp_q.pop_front());
                end
                have_prev = 0;
            end else begin
                have_prev = (inval[15] === 1'b1);
            end
            prev_pkt = inval;
            if (cmd_valid && cmd_ready) begin
                if (cmd_walk)
                    for (int i = 0; i < 256; i++) exp_q.push_back('{mk(1'b1, 8'(i), 2'b00), i == 255});
                else
                    exp_q.push_back('{mk(cmd_all_ways, cmd_index, cmd_way), 1'b1});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic w, input logic aw, input logic [7:0] ix, input logic [1:0] wy);
        cmd_valid = 1'b1; cmd_walk = w; cmd_all_ways = aw; cmd_index = ix; cmd_way = wy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (inval !== 16'h0000) begin errors++; $display("FAIL reset_inval: got %h want 0000", inval); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_single();
        cyc();
        set_cmd(1'b0, 1'b0, 8'h5A, 2'd2);
        cyc();
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (inval !== 16'h9682) begin errors++; $display("FAIL single_pkt: got %h want 9682", inval); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy); end
        checks++; if (inval[15] !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", inval[15]); end
    endtask

    task automatic test_stall_all_ways();
        cyc();
        set_cmd(1'b0, 1'b1, 8'h01, 2'd3);
        stall = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (inval !== 16'hC040) begin errors++; $display("FAIL stall_hold%0d: got %h want C040", k, inval); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_nodone%0d: got %b want 0", k, done); end
            if (k < 2) cyc();
        end
        @(posedge clk);
        #1 stall = 1'b0;
        @(negedge clk);
        checks++; if (inval !== 16'hC040) begin errors++; $display("FAIL stall_accept: got %h want C040", inval); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", done); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_done_once: got %b want 0", done); end
    endtask

    task automatic test_walk();
        int bad = 0;
        cyc();
        set_cmd(1'b1, 1'b0, 8'hA5, 2'd1);
        cyc();
        cmd_valid = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (inval !== mk(1'b1, 8'(i), 2'b00)) begin
                bad++;
                if (bad == 1) $display("FAIL walk_pkt: got %h want %h", inval, mk(1'b1, 8'(i), 2'b00));
            end
        end
        checks++; if (bad != 0) errors++;
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL walk_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL walk_idle: got %b want 0", busy); end
    endtask

    task automatic test_flush();
        int k = 0, held = 0, n = 0;
        cyc();
        set_cmd(1'b1, 1'b0, 8'h00, 2'd0);
        cyc();
        cmd_valid = 1'b0;
        while (k < 256 && n < 400) begin
            @(negedge clk);
            n++;
            checks++;
            if (inval !== mk(1'b1, 8'(k), 2'b00)) begin
                errors++;
                $display("FAIL flush_pkt: got %h want %h", inval, mk(1'b1, 8'(k), 2'b00));
            end
            if (!flush) k++;
            cyc();
            flush = (k == 10 && held < 2);
            if (flush) held++;
        end
        flush = 1'b0;
        checks++; if (n != 258) begin errors++; $display("FAIL flush_cycles: got %0d want 258", n); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL flush_done: got %b want 1", done); end
    endtask

    task automatic test_fifo_full();
        logic [15:0] want[5];
        logic        aw;
        logic [7:0]  ix;
        logic [1:0]  wy;
        cyc();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            aw = 1'($urandom_range(0, 1)); ix = 8'($urandom); wy = 2'($urandom);
            want[i] = mk(aw, ix, wy);
            set_cmd(1'b0, aw, ix, wy);
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_ready%0d: got %b want 1", i, cmd_ready); end
            cyc();
        end
        set_cmd(1'b0, 1'b0, 8'hFF, 2'd3);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_notready: got %b want 0", cmd_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b want 1", busy); end
        cyc();
        cmd_valid = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (inval !== want[i]) begin errors++; $display("FAIL full_order%0d: got %h want %h", i, inval, want[i]); end
            checks++; if (done !== (i > 0)) begin errors++; $display("FAIL full_b2b_done%0d: got %b want %b", i, done, i > 0); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_last_done: got %b want 1", done); end
        checks++; if (inval[15] !== 1'b0) begin errors++; $display("FAIL full_drained: got %b want 0", inval[15]); end
    endtask

    task automatic test_reset_mid_walk();
        int n = 0;
        cyc();
        set_cmd(1'b1, 1'b0, 8'h00, 2'd0);
        cyc();
        cmd_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (inval !== mk(1'b1, 8'd100, 2'b00) && n < 400);
        checks++; if (n >= 400) begin errors++; $display("FAIL midwalk_reach: got timeout want idx 100"); end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (inval !== 16'h0000) begin errors++; $display("FAIL midwalk_inval: got %h want 0000", inval); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midwalk_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midwalk_done: got %b want 0", done); end
        cyc();
        set_cmd(1'b0, 1'b0, 8'h33, 2'd1);
        cyc();
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (inval !== mk(1'b0, 8'h33, 2'd1)) begin errors++; $display("FAIL midwalk_next: got %h want %h", inval, mk(1'b0, 8'h33, 2'd1)); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL midwalk_next_done: got %b want 1", done); end
    endtask

    task automatic test_random();
        int n = 0;
        for (int c = 0; c < 4000; c++) begin
            cyc();
            rst          = ($urandom_range(0, 599) == 0);
            cmd_valid    = ($urandom_range(0, 3) == 0);
            cmd_walk     = ($urandom_range(0, 127) == 0);
            cmd_all_ways = 1'($urandom_range(0, 1));
            cmd_index    = 8'($urandom);
            cmd_way      = 2'($urandom);
            stall        = ($urandom_range(0, 3) == 0);
            flush        = ($urandom_range(0, 7) == 0);
        end
        cyc();
        rst = 1'b0; cmd_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy !== 1'b0 || exp_q.size() != 0) && n < 3000);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL random_drain_busy: got %b want 0", busy); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL random_drain_left: got %0d packets owed want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall_all_ways();
        test_walk();
        test_flush();
        test_fifo_full();
        test_reset_mid_walk();
        test_random();
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end
endmodule
